game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game sequencer for the invaders game. It tracks lives and wave number, freezes gameplay between rounds, and issues reset pulses to the invader field, player and win/lose detector. It sits between the debounced button inputs and the player, invader and collision datapath. It consumes per-event hit/clear pulses and drives mode, freeze and status outputs to the renderer.

## Interface
Parameters:
- NUM_LIVES, 3: lives loaded at game start (1..7).
- NUM_WAVES, 5: waves to clear for a win (1..15).
- DELAY_CYCLES, 130_000_000: length of respawn and inter-wave pause (2 s at 65 MHz); minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  debounced single-cycle start pulse.
- pause  in  1  debounced single-cycle pause toggle pulse (used only with PAUSE_EN).
- player_hit  in  1  single-cycle pulse: player ship hit.
- wave_cleared  in  1  single-cycle pulse: last invader of the wave destroyed.
- mode  out  3  0 TITLE, 1 PLAY, 2 RESPAWN, 3 WAVE_END, 4 GAME_OVER, 5 WIN, 6 PAUSE.
- freeze  out  1  high whenever mode != PLAY; halts invader and bullet movement.
- field_rst  out  1  one-cycle pulse: reload invader field and win/lose detector.
- player_rst  out  1  one-cycle pulse: recentre ship, clear bullets.
- lives  out  3  remaining lives.
- wave  out  4  current wave, 1-based.

## Operation
- State machine with states TITLE, PLAY, RESPAWN, WAVE_END, GAME_OVER, WIN, PAUSE. All outputs are registered.
- TITLE:
  - On start: lives←NUM_LIVES, wave←1, pulse field_rst and player_rst, go to PLAY.
- PLAY:
  - On player_hit: lives←lives−1.
    - If the old lives value was 1, go to GAME_OVER.
    - Otherwise load timer←DELAY_CYCLES−1 and go to RESPAWN.
  - On wave_cleared:
    - If wave==NUM_WAVES, go to WIN.
    - Otherwise load the timer and go to WAVE_END.
  - player_hit and wave_cleared in the same cycle: hit wins and wave_cleared is dropped. Lives still decrement.
- RESPAWN: timer counts down once per cycle. At 0: pulse player_rst, go to PLAY. player_hit and wave_cleared are ignored.
- WAVE_END: timer counts down. At 0: wave←wave+1, pulse field_rst and player_rst, go to PLAY.
- GAME_OVER and WIN:
  - Hold lives and wave.
  - On start, go to TITLE. No reset pulses are issued.
- start is ignored in PLAY, RESPAWN and WAVE_END.
- lives never underflows. wave never exceeds NUM_WAVES.
- Timer width is $clog2(DELAY_CYCLES).

## Timing
- Reset values: mode=TITLE (0), freeze=1, field_rst=0, player_rst=0, lives=0, wave=0, timer=0.
- An input pulse sampled at edge N updates state, mode, lives and freeze at edge N+1. Any reset pulse is high for exactly the cycle following edge N+1.
- RESPAWN and WAVE_END last exactly DELAY_CYCLES cycles. mode returns to PLAY on the edge after the timer reads 0, coincident with the reset pulses.
- field_rst and player_rst are never asserted for more than one consecutive cycle.
- rst mid-round (any state, including a running timer) returns to TITLE with reset values on the next edge. No reset pulse is issued.

## Configuration
- GAME_FLOW_PAUSE_EN defined:
  - pause in PLAY goes to PAUSE; pause in PAUSE returns to PLAY.
  - PAUSE freezes everything and holds lives, wave and timer. player_hit and wave_cleared are ignored in PAUSE.
  - pause in any other state is ignored. pause and player_hit in the same PLAY cycle: hit wins.
- Undefined: the pause port is unused, the PAUSE state does not exist and mode never equals 6.

## Test plan
- Reset then start, NUM_LIVES=3 → next cycle: mode=1, lives=3, wave=1, freeze=0, single-cycle field_rst and player_rst.
- DELAY_CYCLES=4, one player_hit in PLAY → lives=2, mode=2 for exactly 4 cycles, then player_rst pulse and mode=1.
- Three hits (with respawns) → lives=0, mode=4. A fourth hit changes nothing. start → mode=0.
- NUM_WAVES=2, wave_cleared twice → first clear gives WAVE_END, wave=2 plus both reset pulses; second clear gives mode=5.
- player_hit and wave_cleared in the same cycle at lives=2 → mode=2, lives=1, wave unchanged.
- PAUSE_EN defined, pause in PLAY during a DELAY_CYCLES=4 window, rst asserted in PAUSE → mode=6, freeze=1, then reset values on the next edge.

Source files
------------

// File: rtl/game_flow_if.sv
// Handshake bundle between the game sequencer and its surroundings:
// event pulses in, mode/freeze/status and reset pulses out.
interface game_flow_if;
  logic       start;
  logic       pause;
  logic       player_hit;
  logic       wave_cleared;
  logic [2:0] mode;
  logic       freeze;
  logic       field_rst;
  logic       player_rst;
  logic [2:0] lives;
  logic [3:0] wave;

  modport master (
    output start, pause, player_hit, wave_cleared,
    input  mode, freeze, field_rst, player_rst, lives, wave
  );

  modport slave (
    input  start, pause, player_hit, wave_cleared,
    output mode, freeze, field_rst, player_rst, lives, wave
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Invaders game sequencer: lives, waves, respawn/inter-wave pauses and reset pulses.
// Optional pause feature enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_ctrl #(
  parameter int unsigned NUM_LIVES    = 3,
  parameter int unsigned NUM_WAVES    = 5,
  parameter int unsigned DELAY_CYCLES = 130_000_000
) (
  input logic       clk,
  input logic       rst,
  game_flow_if.slave bus
);

  // Width floors at 1 so DELAY_CYCLES == 1 still yields a legal timer.
  localparam int unsigned TW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DELAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_PLAY      = 3'd1,
    S_RESPAWN   = 3'd2,
    S_WAVE_END  = 3'd3,
    S_GAME_OVER = 3'd4,
    S_WIN       = 3'd5
`ifdef GAME_FLOW_PAUSE_EN
    , S_PAUSE   = 3'd6
`endif
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

`ifndef GAME_FLOW_PAUSE_EN
  logic unused_pause;
  assign unused_pause = bus.pause;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_TITLE;
      bus.mode       <= S_TITLE;
      bus.freeze     <= 1'b1;
      bus.field_rst  <= 1'b0;
      bus.player_rst <= 1'b0;
      bus.lives      <= '0;
      bus.wave       <= '0;
      timer          <= '0;
    end else begin
      bus.field_rst  <= 1'b0;
      bus.player_rst <= 1'b0;
      case (state)
        S_TITLE: begin
          if (bus.start) begin
            bus.lives      <= 3'(NUM_LIVES);
            bus.wave       <= 4'd1;
            bus.field_rst  <= 1'b1;
            bus.player_rst <= 1'b1;
            state          <= S_PLAY;
            bus.mode       <= S_PLAY;
            bus.freeze     <= 1'b0;
          end
        end
        S_PLAY: begin
          // A hit takes priority over both a wave clear and a pause.
          if (bus.player_hit) begin
            if (bus.lives != 3'd0) bus.lives <= bus.lives - 3'd1;
            bus.freeze <= 1'b1;
            if (bus.lives <= 3'd1) begin
              state    <= S_GAME_OVER;
              bus.mode <= S_GAME_OVER;
            end else begin
              timer    <= TIMER_LOAD;
              state    <= S_RESPAWN;
              bus.mode <= S_RESPAWN;
            end
          end else if (bus.wave_cleared) begin
            bus.freeze <= 1'b1;
            if (bus.wave >= 4'(NUM_WAVES)) begin
              state    <= S_WIN;
              bus.mode <= S_WIN;
            end else begin
              timer    <= TIMER_LOAD;
              state    <= S_WAVE_END;
              bus.mode <= S_WAVE_END;
            end
          end
`ifdef GAME_FLOW_PAUSE_EN
          else if (bus.pause) begin
            bus.freeze <= 1'b1;
            state      <= S_PAUSE;
            bus.mode   <= S_PAUSE;
          end
`endif
        end
        S_RESPAWN: begin
          if (timer == '0) begin
            bus.player_rst <= 1'b1;
            state          <= S_PLAY;
            bus.mode       <= S_PLAY;
            bus.freeze     <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_WAVE_END: begin
          if (timer == '0) begin
            bus.wave       <= bus.wave + 4'd1;
            bus.field_rst  <= 1'b1;
            bus.player_rst <= 1'b1;
            state          <= S_PLAY;
            bus.mode       <= S_PLAY;
            bus.freeze     <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_GAME_OVER, S_WIN: begin
          if (bus.start) begin
            state    <= S_TITLE;
            bus.mode <= S_TITLE;
          end
        end
`ifdef GAME_FLOW_PAUSE_EN
        S_PAUSE: begin
          if (bus.pause) begin
            state      <= S_PLAY;
            bus.mode   <= S_PLAY;
            bus.freeze <= 1'b0;
          end
        end
`endif
        default: begin
          state      <= S_TITLE;
          bus.mode   <= S_TITLE;
          bus.freeze <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with NUM_LIVES=3, NUM_WAVES=2, DELAY_CYCLES=4.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  game_flow_if gf_bus ();

  game_flow_ctrl #(
    .NUM_LIVES   (3),
    .NUM_WAVES   (2),
    .DELAY_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(gf_bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic expect_all(input string tag, input int m, input int fz, input int l,
                            input int w, input int fr, input int pr);
    check({tag, ".mode"},       int'(gf_bus.mode),       m);
    check({tag, ".freeze"},     int'(gf_bus.freeze),     fz);
    check({tag, ".lives"},      int'(gf_bus.lives),      l);
    check({tag, ".wave"},       int'(gf_bus.wave),       w);
    check({tag, ".field_rst"},  int'(gf_bus.field_rst),  fr);
    check({tag, ".player_rst"}, int'(gf_bus.player_rst), pr);
  endtask

  // Inputs change and outputs are sampled 1 ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic h, input logic c);
    gf_bus.start        = s;
    gf_bus.pause        = p;
    gf_bus.player_hit   = h;
    gf_bus.wave_cleared = c;
    step();
    gf_bus.start        = 1'b0;
    gf_bus.pause        = 1'b0;
    gf_bus.player_hit   = 1'b0;
    gf_bus.wave_cleared = 1'b0;
  endtask

  // Three cycles remaining in a 4-cycle pause, then the return edge.
  task automatic ride_delay(input string tag, input int m, input int l, input int w,
                            input int fr_back, input int w_back);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_all({tag, ".hold"}, m, 1, l, w, 0, 0);
    end
    step();
    expect_all({tag, ".back"}, 1, 0, l, w_back, fr_back, 1);
    step();
    expect_all({tag, ".after"}, 1, 0, l, w_back, 0, 0);
  endtask

  initial begin
    rst                 = 1'b1;
    gf_bus.start        = 1'b0;
    gf_bus.pause        = 1'b0;
    gf_bus.player_hit   = 1'b0;
    gf_bus.wave_cleared = 1'b0;
    step();
    step();
    rst = 1'b0;
    expect_all("reset", 0, 1, 0, 0, 0, 0);

    pulse(0, 0, 1, 1);
    expect_all("title_ignores_events", 0, 1, 0, 0, 0, 0);

    pulse(1, 0, 0, 0);
    expect_all("start", 1, 0, 3, 1, 1, 1);
    step();
    expect_all("start_pulse_end", 1, 0, 3, 1, 0, 0);

    pulse(1, 0, 0, 0);
    expect_all("start_in_play", 1, 0, 3, 1, 0, 0);

    pulse(0, 0, 1, 0);
    expect_all("hit1", 2, 1, 2, 1, 0, 0);
    ride_delay("respawn1", 2, 2, 1, 0, 1);

    pulse(0, 0, 1, 1);
    expect_all("hit_and_clear", 2, 1, 1, 1, 0, 0);
    ride_delay("respawn2", 2, 1, 1, 0, 1);

    pulse(0, 0, 0, 1);
    expect_all("clear1", 3, 1, 1, 1, 0, 0);
    ride_delay("wave_end", 3, 1, 1, 1, 2);

    pulse(0, 0, 0, 1);
    expect_all("clear_last", 5, 1, 1, 2, 0, 0);
    pulse(0, 0, 1, 0);
    expect_all("win_ignores_hit", 5, 1, 1, 2, 0, 0);
    pulse(1, 0, 0, 0);
    expect_all("win_to_title", 0, 1, 1, 2, 0, 0);

    pulse(1, 0, 0, 0);
    expect_all("restart", 1, 0, 3, 1, 1, 1);
    step();
    pulse(0, 0, 1, 0);
    expect_all("g2_hit1", 2, 1, 2, 1, 0, 0);
    ride_delay("g2_resp1", 2, 2, 1, 0, 1);
    pulse(0, 0, 1, 0);
    expect_all("g2_hit2", 2, 1, 1, 1, 0, 0);
    ride_delay("g2_resp2", 2, 1, 1, 0, 1);
    pulse(0, 0, 1, 0);
    expect_all("game_over", 4, 1, 0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    expect_all("hit_after_over", 4, 1, 0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    expect_all("over_to_title", 0, 1, 0, 1, 0, 0);

    pulse(1, 0, 0, 0);
    expect_all("g3_start", 1, 0, 3, 1, 1, 1);
    step();
`ifdef GAME_FLOW_PAUSE_EN
    pulse(0, 1, 0, 0);
    expect_all("pause_on", 6, 1, 3, 1, 0, 0);
    pulse(0, 0, 1, 1);
    expect_all("pause_ignores", 6, 1, 3, 1, 0, 0);
    pulse(0, 1, 0, 0);
    expect_all("pause_off", 1, 0, 3, 1, 0, 0);
    pulse(0, 1, 1, 0);
    expect_all("pause_vs_hit", 2, 1, 2, 1, 0, 0);
    ride_delay("pause_resp", 2, 2, 1, 0, 1);
    pulse(0, 1, 0, 0);
    expect_all("pause_again", 6, 1, 2, 1, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_all("rst_in_pause", 0, 1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0);
    expect_all("pause_in_title", 0, 1, 0, 0, 0, 0);
`else
    pulse(0, 1, 0, 0);
    expect_all("pause_unused", 1, 0, 3, 1, 0, 0);
`endif

    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    step();
    expect_all("pre_rst_respawn", 2, 1, 2, 1, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_all("rst_mid_respawn", 0, 1, 0, 0, 0, 0);
    step();
    expect_all("rst_no_pulse", 0, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
